alu16_seq: RTL and testbench

Multi-cycle sequencer that executes the CPU's 16-bit arithmetic (ADD HL,rr; ADD SP,e8; INC rr; DEC rr) by borrowing the shared 8-bit ALU for two consecutive cycles, low byte then high byte. It chains the low-byte carry into the high-byte ADC/SBC and composes the final Game Boy flag result. It sits between the CPU control unit (request/response handshake) and the ALU operand/opcode mux, and signals the ALU borrow so the main datapath yields the ALU.

---
 rtl/alu16_seq.sv | 173 +++++++++++++++++
 tb/tb_alu16_seq.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/alu16_seq.sv
// alu16_seq: runs the CPU's 16-bit arithmetic (ADD HL,rr / ADD SP,e8 /
// INC rr / DEC rr) as two passes through the shared 8-bit ALU, low byte
// then high byte, chaining the low carry into ADC/SBC and composing the
// resulting {Z,N,H,C} flags.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake from the control unit
//   req_op                 00 ADD16, 01 ADDSP, 10 INC16, 11 DEC16
//   req_a, req_b           operands (ADDSP uses req_b[7:0] as signed e8)
//   req_flags              current F register {Z,N,H,C}
//   rsp_valid/rsp_ready    response handshake
//   rsp_result, rsp_flags  16-bit result and new F value
//   alu_en                 sequencer owns the shared ALU this cycle
//   alu_op/a/b/f_in        ALU opcode, operands and carry-in flags
//   alu_y, alu_f_out       combinational ALU result and flags
//
// Build option: define ALU16_SEQ_INCDEC_FAST_EN to compute INC16/DEC16
// with an internal 16-bit incrementer at the accept edge (1-cycle latency,
// ALU untouched). Default: every op goes through the ALU (3 cycles).
module alu16_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [1:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   input  logic [3:0]  req_flags,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_result,
   output logic [3:0]  rsp_flags,
   output logic        alu_en,
   output logic [4:0]  alu_op,
   output logic [7:0]  alu_a,
   output logic [7:0]  alu_b,
   output logic [3:0]  alu_f_in,
   input  logic [7:0]  alu_y,
   input  logic [3:0]  alu_f_out
);

   localparam int unsigned BW = 8;

   // Shared ALU opcode encodings
   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_ADC = 5'd1;
   localparam logic [4:0] ALU_SUB = 5'd2;
   localparam logic [4:0] ALU_SBC = 5'd3;

   localparam logic [1:0] OP_ADD16 = 2'b00;
   localparam logic [1:0] OP_ADDSP = 2'b01;
   localparam logic [1:0] OP_DEC16 = 2'b11;

   typedef enum logic [1:0] {ST_IDLE, ST_LO, ST_HI, ST_DONE} state_t;

   state_t          state;
   logic [1:0]      op_q;
   logic [BW-1:0]   a_hi_q;   // high byte of first operand
   logic [BW-1:0]   b_hi_q;   // high-byte second operand, already extended
   logic [3:0]      f_q;
   logic [BW-1:0]   lo_q;
   logic            h_lo_q;
   logic            c_lo_q;
   logic            accept;
   logic            fast_op;
   logic [BW-1:0]   b_hi_sel;

   // Z/N out of the ALU are never needed: Z/N come from the composition rules
   logic            unused_alu_zn;
   assign unused_alu_zn = ^alu_f_out[3:2];

   assign accept = req_valid && req_ready;

`ifdef ALU16_SEQ_INCDEC_FAST_EN
   assign fast_op = req_op[1];
`else
   assign fast_op = 1'b0;
`endif

   // High-byte second operand chosen once at accept
   always_comb begin
      b_hi_sel = '0;
      case (req_op)
         OP_ADD16: b_hi_sel = req_b[15:8];
         OP_ADDSP: b_hi_sel = {BW{req_b[7]}};
         default:  b_hi_sel = '0;
      endcase
   end

   // Sequencer FSM; every output is registered
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         req_ready  <= 1'b1;
         rsp_valid  <= 1'b0;
         rsp_result <= '0;
         rsp_flags  <= '0;
         alu_en     <= 1'b0;
         alu_op     <= '0;
         alu_a      <= '0;
         alu_b      <= '0;
         alu_f_in   <= '0;
         op_q       <= '0;
         a_hi_q     <= '0;
         b_hi_q     <= '0;
         f_q        <= '0;
         lo_q       <= '0;
         h_lo_q     <= 1'b0;
         c_lo_q     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  op_q      <= req_op;
                  a_hi_q    <= req_a[15:8];
                  b_hi_q    <= b_hi_sel;
                  f_q       <= req_flags;
                  req_ready <= 1'b0;
                  if (fast_op) begin
                     // INC16/DEC16 bypass the ALU entirely
                     rsp_result <= (req_op == OP_DEC16) ? (req_a - 16'd1) : (req_a + 16'd1);
                     rsp_flags  <= req_flags;
                     rsp_valid  <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     alu_en   <= 1'b1;
                     alu_op   <= (req_op == OP_DEC16) ? ALU_SUB : ALU_ADD;
                     alu_a    <= req_a[7:0];
                     alu_b    <= req_op[1] ? 8'h01 : req_b[7:0];
                     alu_f_in <= '0;
                     state    <= ST_LO;
                  end
               end
            end
            ST_LO: begin
               lo_q     <= alu_y;
               h_lo_q   <= alu_f_out[1];
               c_lo_q   <= alu_f_out[0];
               alu_op   <= (op_q == OP_DEC16) ? ALU_SBC : ALU_ADC;
               alu_a    <= a_hi_q;
               alu_b    <= b_hi_q;
               alu_f_in <= {3'b000, alu_f_out[0]};
               state    <= ST_HI;
            end
            ST_HI: begin
               rsp_result <= {alu_y, lo_q};
               case (op_q)
                  OP_ADD16: rsp_flags <= {f_q[3], 1'b0, alu_f_out[1], alu_f_out[0]};
                  OP_ADDSP: rsp_flags <= {2'b00, h_lo_q, c_lo_q};
                  default:  rsp_flags <= f_q;
               endcase
               rsp_valid <= 1'b1;
               alu_en    <= 1'b0;
               alu_op    <= '0;
               alu_a     <= '0;
               alu_b     <= '0;
               alu_f_in  <= '0;
               state     <= ST_DONE;
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu16_seq.sv
// tb_alu16_seq: directed vector table plus handshake/reset sequences for
// alu16_seq, with a behavioural model of the shared 8-bit ALU.
module tb_alu16_seq;

   localparam logic [4:0] ALU_ADD = 5'd0;
   localparam logic [4:0] ALU_ADC = 5'd1;
   localparam logic [4:0] ALU_SUB = 5'd2;
   localparam logic [4:0] ALU_SBC = 5'd3;

`ifdef ALU16_SEQ_INCDEC_FAST_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready;
   logic [1:0]  req_op;
   logic [15:0] req_a, req_b;
   logic [3:0]  req_flags;
   logic        rsp_valid, rsp_ready;
   logic [15:0] rsp_result;
   logic [3:0]  rsp_flags;
   logic        alu_en;
   logic [4:0]  alu_op;
   logic [7:0]  alu_a, alu_b;
   logic [3:0]  alu_f_in;
   logic [7:0]  alu_y;
   logic [3:0]  alu_f_out;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   alu16_seq dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_flags(req_flags),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_flags(rsp_flags),
      .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
      .alu_f_in(alu_f_in), .alu_y(alu_y), .alu_f_out(alu_f_out)
   );

   // Game Boy style 8-bit ALU: flags {Z,N,H,C}
   always_comb begin
      logic [8:0] s;
      logic [4:0] hs;
      logic       n;
      s  = '0;
      hs = '0;
      n  = 1'b0;
      case (alu_op)
         ALU_ADD, ALU_ADC: begin
            s  = 9'(alu_a) + 9'(alu_b) + ((alu_op == ALU_ADC) ? 9'(alu_f_in[0]) : 9'd0);
            hs = 5'(alu_a[3:0]) + 5'(alu_b[3:0]) + ((alu_op == ALU_ADC) ? 5'(alu_f_in[0]) : 5'd0);
         end
         ALU_SUB, ALU_SBC: begin
            s  = 9'(alu_a) - 9'(alu_b) - ((alu_op == ALU_SBC) ? 9'(alu_f_in[0]) : 9'd0);
            hs = 5'(alu_a[3:0]) - 5'(alu_b[3:0]) - ((alu_op == ALU_SBC) ? 5'(alu_f_in[0]) : 5'd0);
            n  = 1'b1;
         end
         default: ;
      endcase
      alu_y     = s[7:0];
      alu_f_out = {(s[7:0] == 8'h00), n, hs[4], s[8]};
   end

   typedef struct {
      logic [1:0]  op;
      logic [15:0] a;
      logic [15:0] b;
      logic [3:0]  f;
      logic [15:0] exp_r;
      logic [3:0]  exp_f;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " req_ready"},  32'(req_ready),  32'd1);
      check({tag, " rsp_valid"},  32'(rsp_valid),  32'd0);
      check({tag, " rsp_result"}, 32'(rsp_result), 32'd0);
      check({tag, " rsp_flags"},  32'(rsp_flags),  32'd0);
      check({tag, " alu_bus"},    {alu_en, alu_op, alu_a, alu_b, alu_f_in}, 32'd0);
   endtask

   // Present a request, wait for accept, then scramble req_* so late changes are visible.
   task automatic accept_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                            input logic [3:0] f);
      req_op = op; req_a = a; req_b = b; req_flags = f; req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_a = 16'hDEAD; req_b = 16'hBEEF; req_flags = 4'h5; req_op = ~op;
   endtask

   task automatic rsp_handshake(input string tag);
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      rsp_ready = 1'b0;
      check({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
      check({tag, " req_ready back"}, 32'(req_ready), 32'd1);
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int         edges;
      int         n_alu;
      logic [4:0] ops [4];
      bit         fast_path;
      string      tag;
      tag = $sformatf("vec%0d", idx);
      fast_path = FAST && v.op[1];
      check({tag, " ready before"}, 32'(req_ready), 32'd1);
      accept_op(v.op, v.a, v.b, v.f);
      edges = 1;
      n_alu = 0;
      while (!rsp_valid && edges < 10) begin
         if (alu_en && n_alu < 4) begin
            ops[n_alu] = alu_op;
            n_alu++;
         end
         @(posedge clk); #1;
         edges++;
      end
      check({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({tag, " latency"}, 32'(edges), fast_path ? 32'd1 : 32'd3);
      check({tag, " result"}, 32'(rsp_result), 32'(v.exp_r));
      check({tag, " flags"}, 32'(rsp_flags), 32'(v.exp_f));
      check({tag, " alu idle in DONE"}, {alu_en, alu_op, alu_a, alu_b, alu_f_in}, 32'd0);
      check({tag, " req_ready low"}, 32'(req_ready), 32'd0);
      if (fast_path) begin
         check({tag, " alu cycles"}, 32'(n_alu), 32'd0);
      end else begin
         check({tag, " alu cycles"}, 32'(n_alu), 32'd2);
         check({tag, " alu op lo"}, 32'(ops[0]), (v.op == 2'b11) ? 32'(ALU_SUB) : 32'(ALU_ADD));
         check({tag, " alu op hi"}, 32'(ops[1]), (v.op == 2'b11) ? 32'(ALU_SBC) : 32'(ALU_ADC));
      end
      rsp_handshake(tag);
   endtask

   vec_t vecs [9];

   initial begin
      // op, a, b, flags, expected result, expected flags
      vecs[0] = '{2'b00, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010};
      vecs[1] = '{2'b00, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011};
      vecs[2] = '{2'b01, 16'hFFF8, 16'h0008, 4'b1111, 16'h0000, 4'b0011};
      vecs[3] = '{2'b01, 16'h0005, 16'h00FF, 4'b0000, 16'h0004, 4'b0011};
      vecs[4] = '{2'b11, 16'h0000, 16'h5555, 4'b1010, 16'hFFFF, 4'b1010};
      vecs[5] = '{2'b10, 16'h00FF, 16'h0000, 4'b0101, 16'h0100, 4'b0101};
      vecs[6] = '{2'b00, 16'h8000, 16'h8000, 4'b1111, 16'h0000, 4'b1001};
      vecs[7] = '{2'b10, 16'hFFFF, 16'h0000, 4'b0000, 16'h0000, 4'b0000};
      vecs[8] = '{2'b01, 16'h1000, 16'h0080, 4'b0000, 16'h0F80, 4'b0000};

      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_op = '0; req_a = '0; req_b = '0; req_flags = '0;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // Back-pressure: response held while rsp_ready low, new requests ignored
      accept_op(2'b00, 16'h1234, 16'h1111, 4'b0000);
      repeat (2) @(posedge clk);
      #1;
      check("hold first valid", 32'(rsp_valid), 32'd1);
      req_valid = 1'b1; req_op = 2'b10; req_a = 16'h7777; req_b = 16'h0000; req_flags = 4'hF;
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         check($sformatf("hold%0d valid", k), 32'(rsp_valid), 32'd1);
         check($sformatf("hold%0d result", k), 32'(rsp_result), 32'h2345);
         check($sformatf("hold%0d flags", k), 32'(rsp_flags), 32'h0);
         check($sformatf("hold%0d ready", k), 32'(req_ready), 32'd0);
         check($sformatf("hold%0d alu_en", k), 32'(alu_en), 32'd0);
      end
      req_valid = 1'b0;
      rsp_handshake("hold");

      // Reset asserted mid-operation (HI cycle)
      accept_op(2'b00, 16'h00F0, 16'h0010, 4'b1000);
      check("pre-reset LO op", 32'(alu_op), 32'(ALU_ADD));
      @(posedge clk); #1;
      check("pre-reset HI op", 32'(alu_op), 32'(ALU_ADC));
      check("pre-reset result", 32'(rsp_result), 32'h2345);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("async reset");
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      check("post-reset ready", 32'(req_ready), 32'd1);
      check("post-reset valid", 32'(rsp_valid), 32'd0);

      // Normal operation resumes after reset
      run_vec(9, vecs[0]);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   // Absolute watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
